instr_fetch_unit: RTL

Instruction-fetch datapath directly downstream of the CPU controller state machine. It consumes the controller's `load_ir`, `inc_pc`, `load_pc` and `rd` strobes, and contains the 13-bit program counter, the 16-bit instruction register and the memory address multiplexer. It returns `opcode` to the controller and drives the ROM/RAM address bus. The controller updates its strobes on the falling edge of `clk1`; this block samples them on the rising edge, half a cycle later.

---
 rtl/instr_fetch_unit.sv | 97 +++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: program counter, two-half instruction register and
// memory address multiplexer sitting under the CPU controller.
// The controller moves its strobes on the falling edge of clk1; every
// register here samples them on the following rising edge.
module instr_fetch_unit #(
    parameter int unsigned AW = 13,
    parameter int unsigned DW = 8
) (
    input  logic          clk1,
    input  logic          rst_n,
    input  logic          fetch,
    input  logic          load_ir,
    input  logic          inc_pc,
    input  logic          load_pc,
    input  logic          rd,
    input  logic [DW-1:0] data,
    output logic [2:0]    opcode,
    output logic [AW-1:0] ir_addr,
    output logic [AW-1:0] pc_addr,
    output logic [AW-1:0] addr,
    output logic          instr_valid,
    output logic          proto_err
);

    // Full instruction is two data-bus halves; opcode sits above the operand.
    localparam int unsigned IW = 2 * DW;

    // hi_done encoding: EXPECT_LO means the high half has just been taken.
    typedef enum logic {
        EXPECT_HI = 1'b0,
        EXPECT_LO = 1'b1
    } half_state_t;

    half_state_t   hi_done;
    logic [IW-1:0] ir;
    logic [AW-1:0] pc;

    // Half-pairing FSM with the IR and the instr_valid pulse registered alongside.
    // Any cycle without load_ir drops a pending high half so it cannot pair later.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            hi_done     <= EXPECT_HI;
            ir          <= '0;
            instr_valid <= 1'b0;
        end else begin
            instr_valid <= 1'b0;
            case (hi_done)
                EXPECT_HI: begin
                    if (load_ir) begin
                        ir[IW-1:DW] <= data;
                        hi_done     <= EXPECT_LO;
                    end else begin
                        hi_done     <= EXPECT_HI;
                    end
                end
                EXPECT_LO: begin
                    if (load_ir) begin
                        ir[DW-1:0]  <= data;
                        instr_valid <= 1'b1;
                    end
                    hi_done <= EXPECT_HI;
                end
                default: hi_done <= EXPECT_HI;
            endcase
        end
    end

    // Program counter: jump beats increment; the jump target is the operand
    // held before this edge, so a concurrent IR load cannot redirect it.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
        end else if (load_pc) begin
            pc <= ir[AW-1:0];
        end else if (inc_pc) begin
            pc <= pc + AW'(1);
        end
    end

    // Sticky flag for an IR load that was not backed by a memory read.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            proto_err <= 1'b0;
        end else if (load_ir && !rd) begin
            proto_err <= 1'b1;
        end
    end

    // Register views handed back to the controller and the address mux.
    assign opcode  = ir[IW-1:IW-3];
    assign ir_addr = ir[AW-1:0];
    assign pc_addr = pc;

    // Address mux: PC during fetch, instruction operand otherwise.
    assign addr = fetch ? pc : ir[AW-1:0];

endmodule
